// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified instruction/data memory between the
//   fetch stage and the memory-stage load/store unit. Data requests always
//   win over fetch. Each access is a registered request held until
//   mem_ready_i, or until MAX_WAIT cycles of mem_ready_i low have passed.
//   Loads are lane-selected and sign/zero-extended. Stores get byte enables
//   and lane-replicated data. Misaligned or illegal data accesses complete
//   through the ERR state without touching memory.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req_i, if_addr_i             fetch request / byte address
//   if_rdata_o, if_valid_o, if_err_o   fetch completion (one-cycle pulse)
//   dm_rd_i, dm_wr_i, dm_funct3_i   load / store request, size + sign
//   dm_addr_i, dm_wdata_i           data byte address, low-aligned store data
//   dm_rdata_o, dm_valid_o, dm_err_o   data completion (one-cycle pulse)
//   stall_o                         combinational pipeline freeze
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o   memory request
//   mem_ready_i, mem_rdata_i        memory completion / read word
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        if_err_o,
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  input  logic [2:0]  dm_funct3_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_valid_o,
  output logic        dm_err_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   res = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
      2'b01:   res = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc_s;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        if_valid_q, if_err_q;
  logic [31:0] if_rdata_q;
  logic        dm_valid_q, dm_err_q;
  logic [31:0] dm_rdata_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        dm_req_s, if_elig_s;
  logic        dm_legal_s;
  logic [3:0]  dm_be_s;
  logic [31:0] dm_wdata_s;
  logic        done_s, tmo_s;

  // A requester is ignored while its own valid pulse is out: its stage
  // advances at that edge, so the request still showing is the old one.
  assign dm_req_s  = (dm_rd_i | dm_wr_i) & ~dm_valid_q;
  assign if_elig_s = if_req_i & ~if_valid_q;
  assign cnt_inc_s = cnt_q + 8'd1;

  assign stall_o = ((dm_rd_i | dm_wr_i) & ~dm_valid_q) | (if_req_i & ~if_valid_q);

  // Decode size/alignment of the data request into enables and store lanes.
  always_comb begin
    dm_legal_s = 1'b1;
    dm_be_s    = 4'b0000;
    dm_wdata_s = 32'h0000_0000;
    case (dm_funct3_i)
      3'b000, 3'b100: begin
        dm_be_s    = 4'b0001 << dm_addr_i[1:0];
        dm_wdata_s = {4{dm_wdata_i[7:0]}};
      end
      3'b001, 3'b101: begin
        dm_legal_s = ~dm_addr_i[0];
        dm_be_s    = dm_addr_i[1] ? 4'b1100 : 4'b0011;
        dm_wdata_s = {2{dm_wdata_i[15:0]}};
      end
      3'b010: begin
        dm_legal_s = (dm_addr_i[1:0] == 2'b00);
        dm_be_s    = 4'b1111;
        dm_wdata_s = dm_wdata_i;
      end
      default: begin
        dm_legal_s = 1'b0;
      end
    endcase
  end

  // Next state, wait counter and completion/timeout decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (dm_req_s) begin
          state_d = dm_legal_s ? DATA : ERR;
        end else if (if_elig_s) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      DATA, FETCH: begin
        // A ready in the last allowed cycle completes normally.
        if (mem_ready_i) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end else if (cnt_inc_s == MaxWaitC) begin
          tmo_s   = 1'b1;
          cnt_d   = cnt_inc_s;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      dm_valid_q  <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // Completion pulses and their payload last a single cycle.
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= 32'h0000_0000;
      dm_valid_q <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_rdata_q <= 32'h0000_0000;
      case (state_q)
        IDLE: begin
          if (dm_req_s) begin
            if (dm_legal_s) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= dm_wr_i;
              mem_addr_q  <= dm_addr_i & 32'hFFFF_FFFC;
              mem_be_q    <= dm_be_s;
              mem_wdata_q <= dm_wdata_s;
              off_q       <= dm_addr_i[1:0];
              f3_q        <= dm_funct3_i;
            end else begin
              dm_valid_q  <= 1'b1;
              dm_err_q    <= 1'b1;
            end
          end else if (if_elig_s) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i & 32'hFFFF_FFFC;
            mem_be_q    <= 4'b1111;
            mem_wdata_q <= 32'h0000_0000;
          end else begin
            mem_req_q   <= 1'b0;
          end
        end
        DATA, FETCH: begin
          if (done_s || tmo_s) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            if (state_q == DATA) begin
              dm_valid_q <= 1'b1;
              dm_err_q   <= tmo_s;
              dm_rdata_q <= (done_s && !mem_we_q) ?
                            load_ext(mem_rdata_i, off_q, f3_q) : 32'h0000_0000;
            end else begin
              if_valid_q <= 1'b1;
              if_err_q   <= tmo_s;
              if_rdata_q <= done_s ? mem_rdata_i : 32'h0000_0000;
            end
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        ERR: begin
          mem_req_q <= 1'b0;
        end
        default: begin
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign if_err_o    = if_err_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_valid_o  = dm_valid_q;
  assign dm_err_o    = dm_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases followed by a
// randomized sequence of loads, stores and fetches against a behavioural model.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_err;
  logic        dm_rd, dm_wr;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid, dm_err;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_valid_o(if_valid), .if_err_o(if_err),
    .dm_rd_i(dm_rd), .dm_wr_i(dm_wr), .dm_funct3_i(dm_funct3),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata),
    .dm_valid_o(dm_valid), .dm_err_o(dm_err), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory side: entered #1 after the edge where mem_req rose. Returns #1
  // after the edge that ends the access (ready seen or MAX_WAIT low cycles).
  task automatic serve(input int w, input logic [31:0] word, input logic [31:0] exp_addr);
    for (int c = 0; c < MAXW; c++) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_held", mem_addr, exp_addr);
      mem_ready = (c == w);
      mem_rdata = (c == w) ? word : $urandom;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (c == w) break;
    end
    chk("req_dropped", {31'd0, mem_req}, 32'd0);
  endtask

  // Data access from an idle point (#1 after an edge, DUT idle).
  task automatic data_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] word, input int w);
    int          size, off;
    logic        legal, to;
    logic [3:0]  ebe;
    logic [31:0] ewd, mask, v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && (off % size == 0);
    ebe   = 4'(((1 << size) - 1) << off);
    ewd   = (size == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
            (size == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
    mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v     = (word >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    to    = (w >= MAXW);

    dm_rd = ~wr; dm_wr = wr; dm_funct3 = f3; dm_addr = addr; dm_wdata = wd;
    #1;
    chk("dm_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    if (!legal) begin
      chk("err_noreq", {31'd0, mem_req}, 32'd0);
      chk("err_valid", {31'd0, dm_valid}, 32'd1);
      chk("err_flag", {31'd0, dm_err}, 32'd1);
      chk("err_rdata", dm_rdata, 32'd0);
    end else begin
      chk("d_req", {31'd0, mem_req}, 32'd1);
      chk("d_we", {31'd0, mem_we}, {31'd0, wr});
      chk("d_be", {28'd0, mem_be}, {28'd0, ebe});
      if (wr) chk("d_wdata", mem_wdata, ewd);
      serve(w, word, addr & 32'hFFFF_FFFC);
      chk("d_valid", {31'd0, dm_valid}, 32'd1);
      chk("d_err", {31'd0, dm_err}, {31'd0, to});
      chk("d_rdata", dm_rdata, (to || wr) ? 32'd0 : v);
    end
    chk("d_stall_rel", {31'd0, stall}, 32'd0);
    dm_rd = 1'b0; dm_wr = 1'b0;
    @(posedge clk); #1;
    chk("d_pulse_end", {31'd0, dm_valid}, 32'd0);
    chk("d_rdata_clr", dm_rdata, 32'd0);
  endtask

  // Fetch from an idle point.
  task automatic fetch_access(input logic [31:0] addr, input logic [31:0] word, input int w);
    logic to;
    to = (w >= MAXW);
    if_req = 1'b1; if_addr = addr;
    #1;
    chk("f_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("f_req", {31'd0, mem_req}, 32'd1);
    chk("f_be", {28'd0, mem_be}, 32'd15);
    chk("f_we", {31'd0, mem_we}, 32'd0);
    serve(w, word, addr & 32'hFFFF_FFFC);
    chk("f_valid", {31'd0, if_valid}, 32'd1);
    chk("f_err", {31'd0, if_err}, {31'd0, to});
    chk("f_rdata", if_rdata, to ? 32'd0 : word);
    chk("f_no_dvalid", {31'd0, dm_valid}, 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("f_pulse_end", {31'd0, if_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic        wr;
    logic [2:0]  f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_funct3 = 3'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // mem_ready while idle has no effect
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("idle_ready_dv", {31'd0, dm_valid}, 32'd0);
    chk("idle_ready_iv", {31'd0, if_valid}, 32'd0);

    // zero-wait LW at 0x104
    data_access(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 0);
    // LB / LBU at 0x103, SH at 0x102
    data_access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h8012_3456, 1);
    data_access(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h8012_3456, 2);
    data_access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'd0, 0);
    // misaligned word, illegal funct3
    data_access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0);
    data_access(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0);
    // fetch timeout, and ready in the last allowed cycle
    fetch_access(32'h0000_0040, 32'hCAFE_F00D, 10);
    fetch_access(32'h0000_0046, 32'h1357_9BDF, MAXW - 1);

    // simultaneous data + fetch, 3 wait states each
    dm_rd = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h0000_0200;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    @(posedge clk); #1;
    chk("both_first_addr", mem_addr, 32'h0000_0200);
    serve(3, 32'hA5A5_0001, 32'h0000_0200);
    chk("both_dvalid", {31'd0, dm_valid}, 32'd1);
    chk("both_drdata", dm_rdata, 32'hA5A5_0001);
    chk("both_stall", {31'd0, stall}, 32'd1);
    dm_rd = 1'b0;
    @(posedge clk); #1;
    chk("both_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("both_fetch_addr", mem_addr, 32'h0000_0300);
    serve(3, 32'h0BAD_C0DE, 32'h0000_0300);
    chk("both_ivalid", {31'd0, if_valid}, 32'd1);
    chk("both_irdata", if_rdata, 32'h0BAD_C0DE);
    if_req = 1'b0;
    @(posedge clk); #1;

    // reset during a store wait
    dm_wr = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h0000_0500; dm_wdata = 32'h7654_3210;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_be", {28'd0, mem_be}, 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd1);
    dm_wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fetch_access(32'h0000_0080, 32'h2468_ACE0, 0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        fetch_access($urandom, $urandom, $urandom_range(0, 5));
      end else begin
        f3 = f3_tab[$urandom_range(0, 7)];
        wr = 1'($urandom_range(0, 1));
        if (f3 == 3'd4 || f3 == 3'd5) wr = 1'b0;
        data_access(wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the fetch stage and the memory-stage load/store.
- Arbitrates the two requesters, runs a registered request/ready handshake to the memory, and returns fetched words and extended load data.
- Generates the global `stall` that freezes the pipeline registers.
- Turns memory-stage `funct3` and address into byte enables and store lane replication, and detects misaligned/illegal accesses and memory timeouts.

## Interface
- `MAX_WAIT`, default 15: cycles `mem_ready` may stay low during an access before it is aborted (range 1..255).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch requests instruction word.
- `if_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `if_rdata`  out  32  fetched word, valid with `if_valid`.
- `if_valid`  out  1  one-cycle completion pulse for fetch.
- `if_err`  out  1  fetch timed out, pulses with `if_valid`.
- `dm_rd`, `dm_wr`  in  1  memory-stage load / store request; never both high.
- `dm_funct3`  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  store data, low-aligned.
- `dm_rdata`  out  32  extended load data, valid with `dm_valid`.
- `dm_valid`  out  1  one-cycle completion pulse for load/store.
- `dm_err`  out  1  misaligned, illegal `funct3` or timeout, pulses with `dm_valid`.
- `stall`  out  1  combinational pipeline freeze.
- `mem_req`, `mem_we`  out  1  memory request / write.
- `mem_addr`  out  32  word address, bits [1:0] = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  memory completes the access in the cycle it is high.
- `mem_rdata`  in  32  read word, sampled when `mem_ready` = 1.

## Operation
- FSM states: IDLE, DATA, FETCH, ERR.
- IDLE, eligible data request (`dm_rd|dm_wr` and `dm_valid` = 0): data always beats fetch.
  - Legal and aligned: latch addr/be/wdata/we, go DATA.
  - Otherwise go ERR.
- IDLE, otherwise, eligible fetch request (`if_req` and `if_valid` = 0): latch the word address, go FETCH.
- A requester is ineligible in the cycle its own valid is high, because its pipeline stage advances at that edge.
- DATA/FETCH:
  - `mem_req` = 1, with address/controls driven from registers and stable throughout.
  - On `mem_ready` = 1: capture data, pulse the matching valid next cycle, return to IDLE.
- Wait counter: cleared on entry to DATA/FETCH, increments each cycle `mem_ready` = 0.
  - When it reaches `MAX_WAIT`: drop `mem_req`, pulse valid with err = 1 and rdata = 0, go IDLE.
- ERR:
  - Pulse `dm_valid` and `dm_err` with `dm_rdata` = 0; no memory access.
  - Next state IDLE.
- Misaligned access: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0. Illegal `funct3`: 011, 110, 111.
- Byte enables by size:
  - Byte: `be` = 1 << `addr[1:0]`.
  - Half: `be` = 0011 if `addr[1]` = 0, else 1100.
  - Word: `be` = 1111.
  - Fetch: `be` = 1111, `mem_we` = 0.
- Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → unchanged.
- Load data: select the lane given by the latched `addr[1:0]`. `funct3[2]` = 0 sign-extends, 1 zero-extends. Stores return `dm_rdata` = 0.
- `stall` = ((`dm_rd`|`dm_wr`) & ~`dm_valid`) | (`if_req` & ~`if_valid`).

## Timing
- Reset, asynchronous: state IDLE, counter 0. Every output 0 immediately, except `stall`, which follows its equation.
  - A transaction cut by reset is abandoned; the memory must tolerate `mem_req` dropping.
- Request seen in IDLE at cycle t → `mem_req` high from t+1.
  - With `mem_ready` at t+1+w, valid/rdata are high in cycle t+2+w.
  - Zero-wait access: 2 cycles. ERR path: valid at t+1.
- Valid pulses last exactly one cycle; rdata/err are held only in that cycle and are 0 otherwise.
- Simultaneous data + fetch in IDLE: data serviced first. Fetch becomes eligible in the IDLE cycle after `dm_valid`, giving back-to-back accesses with one IDLE cycle between.
- `mem_ready` outside DATA/FETCH is ignored.
- `mem_ready` in the same cycle the counter hits `MAX_WAIT`: the completion wins, err = 0.

## Test plan
- Zero-wait LW, `dm_addr` 0x104, `mem_rdata` 0xDEADBEEF → `mem_addr` 0x104, `be` 1111, `dm_valid` at t+2, `dm_rdata` 0xDEADBEEF, `stall` high cycles t..t+1.
- LB at 0x103 with `mem_rdata` 0x80xxxxxx → `be` 1000, `dm_rdata` 0xFFFFFF80. Same access as LBU → 0x00000080. SH 0x1234 at 0x102 → `be` 1100, `mem_wdata` 0x12341234, `mem_we` 1.
- `dm_rd` and `if_req` raised in the same cycle, 3 wait states each → data completes first; fetch `mem_req` starts after one IDLE cycle; `if_valid` follows with the correct word.
- LW at 0x101 → no `mem_req`, `dm_valid` = `dm_err` = 1 at t+1, `dm_rdata` 0. `funct3` = 011 behaves the same.
- `mem_ready` held low with `MAX_WAIT` = 4 → `mem_req` drops after 4 wait cycles; `if_valid` = `if_err` = 1, `if_rdata` 0.
- `rst_n` pulled low during a DATA wait → all outputs 0 asynchronously. After release, a new fetch completes normally.
